store_buffer: RTL and testbench

//  M-stage store path: write-side counterpart of the W-stage load extender. Turns a store
//  (SW/SH/SB) into a word-aligned address, byte enables and lane-replicated data, queues
//  it in a small FIFO and drains it to data memory over a req/ack handshake. Flags

---
 rtl/store_buffer_pkg.sv | 25 ++
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer_align.sv | 35 +++
 rtl/store_buffer.sv | 89 ++++++++
 tb/tb_store_buffer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store/load encodings: BEOp codes, byte-enable patterns and the FIFO entry layout.
package store_buffer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] BE_WORD = 2'b00;
    localparam logic [1:0] BE_HALF = 2'b01;
    localparam logic [1:0] BE_BYTE = 2'b10;
    localparam logic [1:0] BE_RSVD = 2'b11;

    localparam logic [BE_W-1:0] BEN_NONE    = 4'b0000;
    localparam logic [BE_W-1:0] BEN_WORD    = 4'b1111;
    localparam logic [BE_W-1:0] BEN_LO_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BEN_HI_HALF = 4'b1100;
    localparam logic [BE_W-1:0] BEN_BYTE0   = 4'b0001;

    typedef struct packed {
        logic [ADDR_W-3:0] waddr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-path bus: M-stage store/load requests on one side, data-memory write port on the other.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_beop;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              ades;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_conflict;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              empty;

    modport master (
        output st_valid, st_beop, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        input  st_ready, ades, ld_conflict, mem_req, mem_addr, mem_be, mem_wdata, empty
    );

    modport slave (
        input  st_valid, st_beop, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        output st_ready, ades, ld_conflict, mem_req, mem_addr, mem_be, mem_wdata, empty
    );

endinterface

// File: rtl/store_buffer_align.sv
// Store aligner: BEOp + low address bits -> byte enables, lane-replicated data, misalignment.
module store_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]        beop_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misaligned_o
);

    always_comb begin
        be_o         = BEN_NONE;
        wdata_o      = data_i;
        misaligned_o = 1'b0;
        case (beop_i)
            BE_WORD: begin
                be_o         = BEN_WORD;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            BE_HALF: begin
                be_o         = addr_lo_i[1] ? BEN_HI_HALF : BEN_LO_HALF;
                wdata_o      = {2{data_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            BE_BYTE: begin
                be_o    = BEN_BYTE0 << addr_lo_i;
                wdata_o = {4{data_i[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// M-stage store buffer: aligns stores, queues them in a small FIFO and drains them to memory.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    sb_entry_t         entry_q [DEPTH];
    sb_entry_t         head;
    logic [BE_W-1:0]   al_be;
    logic [DATA_W-1:0] al_wdata;
    logic              al_mis;
    logic              full, empty_w, push, pop, hit;
    logic [PTR_W-1:0]  slot_off;
    logic              unused_ld_lo;

    store_align u_align (
        .beop_i       (bus.st_beop),
        .addr_lo_i    (bus.st_addr[1:0]),
        .data_i       (bus.st_data),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .misaligned_o (al_mis)
    );

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign push    = bus.st_valid & ~full & ~al_mis & (bus.st_beop != BE_RSVD);
    assign pop     = ~empty_w & bus.mem_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry payload needs no reset: slots are only observed while inside [rd_ptr, wr_ptr).
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr_q[PTR_W-1:0]] <= '{waddr: bus.st_addr[ADDR_W-1:2],
                                              be:    al_be,
                                              wdata: al_wdata};
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        hit      = 1'b0;
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr_q[PTR_W-1:0];
            if (((PTR_W+1)'(slot_off) < count) &&
                (entry_q[PTR_W'(i)].waddr == bus.ld_addr[ADDR_W-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign head            = entry_q[rd_ptr_q[PTR_W-1:0]];
    assign unused_ld_lo    = ^bus.ld_addr[1:0];

    assign bus.st_ready    = ~full;
    assign bus.ades        = bus.st_valid & al_mis;
    assign bus.ld_conflict = bus.ld_valid & hit;
    assign bus.mem_req     = ~empty_w;
    assign bus.mem_addr    = {head.waddr, 2'b00};
    assign bus.mem_be      = head.be;
    assign bus.mem_wdata   = head.wdata;
    assign bus.empty       = empty_w;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed stores, memory-side monitor checks FIFO order.
module tb_store_buffer;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    store_buffer_if sb_if ();

    store_buffer #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        sb_if.st_valid = 1'b1;
        sb_if.st_beop  = op;
        sb_if.st_addr  = a;
        sb_if.st_data  = d;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.be   = be;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int k = 0;
        sb_if.st_valid = 1'b0;
        sb_if.mem_ack  = 1'b1;
        while (sb_if.empty !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        sb_if.mem_ack = 1'b0;
        check("drain_done", 32'(sb_if.empty), 32'd1);
    endtask

    // Memory-side monitor: each accepted handshake must match the oldest expected store.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_if.mem_req === 1'b1 && sb_if.mem_ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h, expected no write", sb_if.mem_addr);
                end else begin
                    e = sb_q.pop_front();
                    check("mem_addr", sb_if.mem_addr, e.addr);
                    check("mem_be", 32'(sb_if.mem_be), 32'(e.be));
                    check("mem_wdata", sb_if.mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        sb_if.st_valid = 1'b0;
        sb_if.st_beop  = 2'b00;
        sb_if.st_addr  = '0;
        sb_if.st_data  = '0;
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = '0;
        sb_if.mem_ack  = 1'b0;

        // reset state
        step();
        step();
        @(negedge clk);
        check("rst_mem_req", 32'(sb_if.mem_req), 32'd0);
        check("rst_empty", 32'(sb_if.empty), 32'd1);
        check("rst_st_ready", 32'(sb_if.st_ready), 32'd1);
        check("rst_ld_conflict", 32'(sb_if.ld_conflict), 32'd0);
        sb_if.ld_valid = 1'b0;
        step();
        reset = 1'b1;

        // SB to byte 3: no bypass, visible next cycle
        step();
        store(2'b10, 32'h0000_0013, 32'h1234_56AB);
        expect_write(32'h10, 4'b1000, 32'hABAB_ABAB);
        @(negedge clk);
        check("sb_ades", 32'(sb_if.ades), 32'd0);
        check("sb_no_bypass", 32'(sb_if.mem_req), 32'd0);
        step();
        sb_if.st_valid = 1'b0;
        @(negedge clk);
        check("sb_mem_req", 32'(sb_if.mem_req), 32'd1);
        check("sb_mem_addr", sb_if.mem_addr, 32'h10);
        check("sb_mem_be", 32'(sb_if.mem_be), 32'b1000);
        check("sb_mem_wdata", sb_if.mem_wdata, 32'hABAB_ABAB);
        step();
        drain();

        // SH upper half, then misaligned SH, reserved op and misaligned SW all dropped
        store(2'b01, 32'h0000_0022, 32'hBEEF_CAFE);
        expect_write(32'h20, 4'b1100, 32'hCAFE_CAFE);
        step();
        drain();
        store(2'b01, 32'h0000_0021, 32'hBEEF_CAFE);
        @(negedge clk);
        check("sh_mis_ades", 32'(sb_if.ades), 32'd1);
        step();
        store(2'b11, 32'h0000_0000, 32'h5555_5555);
        @(negedge clk);
        check("rsvd_ades", 32'(sb_if.ades), 32'd0);
        step();
        store(2'b00, 32'h0000_0002, 32'h6666_6666);
        @(negedge clk);
        check("sw_mis_ades", 32'(sb_if.ades), 32'd1);
        step();
        sb_if.st_valid = 1'b0;
        @(negedge clk);
        check("dropped_empty", 32'(sb_if.empty), 32'd1);
        step();

        // Fill to DEPTH with ack low, hold a third store, then drain in order
        store(2'b00, 32'h0000_0100, 32'h1111_1111);
        expect_write(32'h100, 4'b1111, 32'h1111_1111);
        step();
        store(2'b00, 32'h0000_0104, 32'h2222_2222);
        expect_write(32'h104, 4'b1111, 32'h2222_2222);
        @(negedge clk);
        check("fill1_ready", 32'(sb_if.st_ready), 32'd1);
        step();
        store(2'b00, 32'h0000_0108, 32'h3333_3333);
        expect_write(32'h108, 4'b1111, 32'h3333_3333);
        @(negedge clk);
        check("full_ready", 32'(sb_if.st_ready), 32'd0);
        check("full_head_addr", sb_if.mem_addr, 32'h100);
        step();
        @(negedge clk);
        check("hold_head_addr", sb_if.mem_addr, 32'h100);
        check("hold_head_data", sb_if.mem_wdata, 32'h1111_1111);
        check("hold_ready", 32'(sb_if.st_ready), 32'd0);
        step();
        sb_if.mem_ack = 1'b1;
        @(negedge clk);
        check("ack_no_comb_ready", 32'(sb_if.st_ready), 32'd0);
        step();
        @(negedge clk);
        check("ready_after_pop", 32'(sb_if.st_ready), 32'd1);
        step();
        sb_if.st_valid = 1'b0;
        step();
        drain();

        // Load-hit detection against a pending store
        store(2'b00, 32'h0000_0040, 32'hDEAD_BEEF);
        expect_write(32'h40, 4'b1111, 32'hDEAD_BEEF);
        step();
        sb_if.st_valid = 1'b0;
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = 32'h42;
        @(negedge clk);
        check("ld_hit", 32'(sb_if.ld_conflict), 32'd1);
        step();
        sb_if.ld_addr = 32'h44;
        @(negedge clk);
        check("ld_miss", 32'(sb_if.ld_conflict), 32'd0);
        step();
        sb_if.ld_addr = 32'h42;
        sb_if.mem_ack = 1'b1;
        @(negedge clk);
        check("ld_hit_acked_head", 32'(sb_if.ld_conflict), 32'd1);
        step();
        sb_if.mem_ack = 1'b0;
        @(negedge clk);
        check("ld_after_drain", 32'(sb_if.ld_conflict), 32'd0);
        check("ld_drained_empty", 32'(sb_if.empty), 32'd1);
        sb_if.ld_valid = 1'b0;
        step();

        // Simultaneous push and pop at count=1
        store(2'b00, 32'h0000_0200, 32'hAAAA_0000);
        expect_write(32'h200, 4'b1111, 32'hAAAA_0000);
        step();
        store(2'b10, 32'h0000_0201, 32'h0000_00CD);
        expect_write(32'h200, 4'b0010, 32'hCDCD_CDCD);
        sb_if.mem_ack = 1'b1;
        step();
        sb_if.st_valid = 1'b0;
        sb_if.mem_ack  = 1'b0;
        @(negedge clk);
        check("pp_mem_req", 32'(sb_if.mem_req), 32'd1);
        check("pp_head_be", 32'(sb_if.mem_be), 32'b0010);
        check("pp_head_data", sb_if.mem_wdata, 32'hCDCD_CDCD);
        check("pp_ready", 32'(sb_if.st_ready), 32'd1);
        step();
        drain();

        // Async reset mid-handshake discards both pending stores
        store(2'b00, 32'h0000_0300, 32'h7777_7777);
        step();
        store(2'b00, 32'h0000_0304, 32'h8888_8888);
        step();
        sb_if.st_valid = 1'b0;
        sb_if.mem_ack  = 1'b1;
        #2;
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("rst_mid_mem_req", 32'(sb_if.mem_req), 32'd0);
        check("rst_mid_empty", 32'(sb_if.empty), 32'd1);
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        check("post_rst_empty", 32'(sb_if.empty), 32'd1);
        check("post_rst_mem_req", 32'(sb_if.mem_req), 32'd0);
        sb_if.mem_ack = 1'b0;
        step();

        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
